// File: rtl/motor_cmd_ramp_pkg.sv
// Shared types and defaults for the motor command ramp block.
package motor_cmd_pkg;
  localparam int DUTY_W = 18;
  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DECEL = 2'd2,
    ST_DEAD  = 2'd3
  } ch_state_e;

  localparam duty_t PERIOD  = 18'd200000;
  localparam duty_t DUTY_LO = 18'd50000;
  localparam duty_t DUTY_HI = 18'd150000;

  // One ramp step from cur toward tgt, never overshooting tgt.
  function automatic duty_t ramp_next(duty_t cur, duty_t tgt, duty_t step);
    logic [DUTY_W:0] up;
    duty_t           dn;
    up = {1'b0, cur} + {1'b0, step};
    dn = (cur < step) ? '0 : cur - step;
    if (cur < tgt)      ramp_next = (up > {1'b0, tgt}) ? tgt : up[DUTY_W-1:0];
    else if (cur > tgt) ramp_next = (dn < tgt) ? tgt : dn;
    else                ramp_next = cur;
  endfunction
endpackage

// File: rtl/motor_cmd_ramp_channel.sv
// One motor channel: switch sync/debounce, reversal-safe FSM and duty ramp.
module motor_ramp_channel
  import motor_cmd_pkg::*;
#(
  parameter duty_t PERIOD      = motor_cmd_pkg::PERIOD,
  parameter duty_t DUTY_LO     = motor_cmd_pkg::DUTY_LO,
  parameter duty_t DUTY_HI     = motor_cmd_pkg::DUTY_HI,
  parameter duty_t RAMP_STEP   = 18'd5000,
  parameter int    DEAD_CYCLES = 1000000,
  parameter int    DEB_CYCLES  = 500000
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  tick,
  input  logic  sw_en,
  input  logic  sw_dir,
  input  logic  sw_spd,
  output duty_t duty,
  output logic  dir_q,
  output logic  busy
);
  localparam int DBW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DBW-1:0] DEB_LAST  = DBW'(DEB_CYCLES - 1);
  localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEAD_CYCLES - 1);

  // bit 0 = enable, bit 1 = direction, bit 2 = speed select
  logic [2:0]          s1, s2, db;
  logic [2:0][DBW-1:0] deb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '0;
      s2      <= '0;
      db      <= '0;
      deb_cnt <= '0;
    end else begin
      s1 <= {sw_spd, sw_dir, sw_en};
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == db[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          db[i]      <= s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DBW'(1);
        end
      end
    end
  end

  logic en_db, dir_db, spd_db;
  assign en_db  = db[0];
  assign dir_db = db[1];
  assign spd_db = db[2];

  ch_state_e      state;
  logic [DCW-1:0] dead_cnt;
  duty_t          tgt_raw, tgt, duty_nxt;

  // DECEL shares the ramp path with a zero target.
  always_comb begin
    tgt_raw  = (state == ST_RUN && en_db) ? (spd_db ? DUTY_LO : DUTY_HI) : '0;
    tgt      = (tgt_raw > PERIOD) ? PERIOD : tgt_raw;
    duty_nxt = ramp_next(duty, tgt, RAMP_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      duty     <= '0;
      dir_q    <= 1'b0;
      dead_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          duty <= '0;
          if (en_db) begin
            dir_q <= dir_db;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) duty <= duty_nxt;
          if (dir_db != dir_q)            state <= ST_DECEL;
          else if (!en_db && duty == '0)  state <= ST_IDLE;
        end
        ST_DECEL: begin
          if (tick) duty <= duty_nxt;
          if (dir_db == dir_q) begin
            state <= ST_RUN;
          end else if (duty == '0) begin
            state    <= ST_DEAD;
            dead_cnt <= '0;
          end
        end
        ST_DEAD: begin
          duty <= '0;
          // Direction is sampled only at expiry; toggles mid-count are ignored.
          if (dead_cnt == DEAD_LAST) begin
            dir_q <= dir_db;
            state <= en_db ? ST_RUN : ST_IDLE;
          end else begin
            dead_cnt <= dead_cnt + DCW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_DECEL) || (state == ST_DEAD);
endmodule

// File: rtl/motor_cmd_ramp.sv
// Two-channel motor command stage: shared ramp tick plus per-channel ramp FSMs.
module motor_cmd_ramp
  import motor_cmd_pkg::*;
#(
  parameter duty_t PERIOD      = motor_cmd_pkg::PERIOD,
  parameter duty_t DUTY_LO     = motor_cmd_pkg::DUTY_LO,
  parameter duty_t DUTY_HI     = motor_cmd_pkg::DUTY_HI,
  parameter int    RAMP_DIV    = 100000,
  parameter duty_t RAMP_STEP   = 18'd5000,
  parameter int    DEAD_CYCLES = 1000000,
  parameter int    DEB_CYCLES  = 500000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [1:0]  sw_en,
  input  logic [1:0]  sw_dir,
  input  logic [1:0]  sw_spd,
  output logic [17:0] duty_a,
  output logic [17:0] duty_b,
  output logic        in1_a,
  output logic        in2_a,
  output logic        in1_b,
  output logic        in2_b,
  output logic [1:0]  busy
);
  localparam int NUM_CH = 2;
  localparam int DVW    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [DVW-1:0] div_cnt;
  logic           tick;

  assign tick = (div_cnt == DVW'(RAMP_DIV - 1));

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) div_cnt <= '0;
    else             div_cnt <= tick ? '0 : div_cnt + DVW'(1);
  end

  duty_t [NUM_CH-1:0] duty;
  logic  [NUM_CH-1:0] dir_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    motor_ramp_channel #(
      .PERIOD      (PERIOD),
      .DUTY_LO     (DUTY_LO),
      .DUTY_HI     (DUTY_HI),
      .RAMP_STEP   (RAMP_STEP),
      .DEAD_CYCLES (DEAD_CYCLES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_ch (
      .clk    (CLK100MHZ),
      .rst_n  (CPU_RESETN),
      .tick   (tick),
      .sw_en  (sw_en[c]),
      .sw_dir (sw_dir[c]),
      .sw_spd (sw_spd[c]),
      .duty   (duty[c]),
      .dir_q  (dir_q[c]),
      .busy   (busy[c])
    );
  end

  assign duty_a = duty[0];
  assign duty_b = duty[1];
  assign in1_a  = dir_q[0];
  assign in2_a  = ~dir_q[0];
  assign in1_b  = dir_q[1];
  assign in2_b  = ~dir_q[1];
endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Self-checking bench for motor_cmd_ramp against a cycle-level behavioural model.
module tb_motor_cmd_ramp;
  localparam int PERIOD      = 200000;
  localparam int DUTY_LO     = 5000;
  localparam int DUTY_HI     = 15000;
  localparam int RAMP_DIV    = 4;
  localparam int RAMP_STEP   = 1000;
  localparam int DEAD_CYCLES = 8;
  localparam int DEB_CYCLES  = 3;

  localparam int P_IDLE = 0, P_RUN = 1, P_DECEL = 2, P_DEAD = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sw_en, sw_dir, sw_spd;
  logic [17:0] duty_a, duty_b;
  logic        in1_a, in2_a, in1_b, in2_b;
  logic [1:0]  busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  motor_cmd_ramp #(
    .PERIOD      (18'(PERIOD)),
    .DUTY_LO     (18'(DUTY_LO)),
    .DUTY_HI     (18'(DUTY_HI)),
    .RAMP_DIV    (RAMP_DIV),
    .RAMP_STEP   (18'(RAMP_STEP)),
    .DEAD_CYCLES (DEAD_CYCLES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .sw_en      (sw_en),
    .sw_dir     (sw_dir),
    .sw_spd     (sw_spd),
    .duty_a     (duty_a),
    .duty_b     (duty_b),
    .in1_a      (in1_a),
    .in2_a      (in2_a),
    .in1_b      (in1_b),
    .in2_b      (in2_b),
    .busy       (busy)
  );

  // Behavioural model: raw switches are seen two edges late, accepted once
  // they have been stable for DEB_CYCLES edges, then drive a phase machine.
  int         m_edge;
  logic [2:0] m_r1 [2];
  logic [2:0] m_r2 [2];
  logic [2:0] m_db [2];
  int         m_chg [2][3];
  int         m_phase [2];
  int         m_duty [2];
  logic       m_dir [2];
  int         m_dead_left [2];

  function automatic int approach(int d, int t);
    int cap;
    cap = (t > PERIOD) ? PERIOD : t;
    if (cap > d) return (d + RAMP_STEP > cap) ? cap : d + RAMP_STEP;
    return (d - RAMP_STEP < cap) ? cap : d - RAMP_STEP;
  endfunction

  task automatic model_reset();
    m_edge = 0;
    for (int c = 0; c < 2; c++) begin
      m_r1[c] = '0; m_r2[c] = '0; m_db[c] = '0;
      m_phase[c] = P_IDLE; m_duty[c] = 0; m_dir[c] = 1'b0; m_dead_left[c] = 0;
      for (int b = 0; b < 3; b++) m_chg[c][b] = 0;
    end
  endtask

  task automatic model_step();
    bit         tick;
    int         d0, tgt;
    logic       en, dir, spd;
    logic [2:0] raw [2];
    tick   = (m_edge % RAMP_DIV) == RAMP_DIV - 1;
    raw[0] = {sw_spd[0], sw_dir[0], sw_en[0]};
    raw[1] = {sw_spd[1], sw_dir[1], sw_en[1]};
    for (int c = 0; c < 2; c++) begin
      en = m_db[c][0]; dir = m_db[c][1]; spd = m_db[c][2];
      d0 = m_duty[c];
      case (m_phase[c])
        P_IDLE: if (en) begin m_dir[c] = dir; m_phase[c] = P_RUN; end
        P_RUN: begin
          tgt = en ? (spd ? DUTY_LO : DUTY_HI) : 0;
          if (tick) m_duty[c] = approach(d0, tgt);
          if (dir != m_dir[c])      m_phase[c] = P_DECEL;
          else if (!en && d0 == 0)  m_phase[c] = P_IDLE;
        end
        P_DECEL: begin
          if (tick) m_duty[c] = approach(d0, 0);
          if (dir == m_dir[c]) m_phase[c] = P_RUN;
          else if (d0 == 0) begin m_phase[c] = P_DEAD; m_dead_left[c] = DEAD_CYCLES; end
        end
        default: begin
          m_dead_left[c]--;
          if (m_dead_left[c] == 0) begin
            m_dir[c]   = dir;
            m_phase[c] = en ? P_RUN : P_IDLE;
          end
        end
      endcase
      for (int b = 0; b < 3; b++)
        if (m_r2[c][b] != m_db[c][b] && m_edge - m_chg[c][b] >= DEB_CYCLES)
          m_db[c][b] = m_r2[c][b];
      for (int b = 0; b < 3; b++)
        if (m_r1[c][b] != m_r2[c][b]) m_chg[c][b] = m_edge;
      m_r2[c] = m_r1[c];
      m_r1[c] = raw[c];
    end
    m_edge++;
  endtask

  function automatic logic [41:0] exp_outs();
    logic [1:0] b;
    for (int c = 0; c < 2; c++) b[c] = (m_phase[c] == P_DECEL) || (m_phase[c] == P_DEAD);
    return {18'(m_duty[0]), 18'(m_duty[1]), m_dir[0], ~m_dir[0], m_dir[1], ~m_dir[1], b};
  endfunction

  function automatic logic [41:0] dut_outs();
    return {duty_a, duty_b, in1_a, in2_a, in1_b, in2_b, busy};
  endfunction

  // One clock: model follows the edge, caller resumes at the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw_en = '0; sw_dir = '0; sw_spd = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (duty_a !== 18'd0) begin errors++; $display("FAIL reset_duty_a: got %0d expected 0", duty_a); end
    checks++; if (duty_b !== 18'd0) begin errors++; $display("FAIL reset_duty_b: got %0d expected 0", duty_b); end
    checks++; if ({in1_a, in2_a, in1_b, in2_b} !== 4'b0101) begin errors++; $display("FAIL reset_pins: got %b expected 0101", {in1_a, in2_a, in1_b, in2_b}); end
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b expected 00", busy); end
    rst_n = 1'b1;
    repeat (6) begin
      cyc();
      checks++; if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL reset_model t=%0t: got %h expected %h", $time, dut_outs(), exp_outs()); end
    end
  endtask

  task automatic test_soft_start();
    int prev, delta;
    sw_en[0] = 1'b1; sw_spd[0] = 1'b1;
    prev = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      checks++; if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL soft_start_model t=%0t: got %h expected %h", $time, dut_outs(), exp_outs()); end
      delta = int'(duty_a) - prev;
      if (delta != 0) begin
        checks++; if (delta != RAMP_STEP) begin errors++; $display("FAIL soft_start_step: got %0d expected %0d", delta, RAMP_STEP); end
      end
      prev = int'(duty_a);
    end
    checks++; if (duty_a !== 18'(DUTY_LO)) begin errors++; $display("FAIL soft_start_final: got %0d expected %0d", duty_a, DUTY_LO); end
    checks++; if ({in1_a, in2_a} !== 2'b01) begin errors++; $display("FAIL soft_start_pins: got %b expected 01", {in1_a, in2_a}); end
  endtask

  task automatic test_reversal();
    int  prev, downs, zb, pin_duty;
    bit  done, seen_busy, pin_seen;
    sw_spd[0] = 1'b0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      cyc();
      checks++; if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL reversal_model t=%0t: got %h expected %h", $time, dut_outs(), exp_outs()); end
      done = (duty_a == 18'(DUTY_HI));
    end
    checks++; if (!done) begin errors++; $display("FAIL reversal_reach_hi: got %0d expected %0d", duty_a, DUTY_HI); end
    sw_dir[0] = 1'b1;
    prev = int'(duty_a); downs = 0; zb = 0; pin_duty = -1;
    done = 0; seen_busy = 0; pin_seen = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      cyc();
      checks++; if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL reversal_model t=%0t: got %h expected %h", $time, dut_outs(), exp_outs()); end
      if (busy[0]) seen_busy = 1;
      if (int'(duty_a) < prev) downs++;
      if (busy[0] && duty_a == 18'd0) zb++;
      if (in1_a && !pin_seen) begin pin_seen = 1; pin_duty = int'(duty_a); end
      prev = int'(duty_a);
      done = in1_a && duty_a == 18'(DUTY_HI);
    end
    checks++; if (!seen_busy) begin errors++; $display("FAIL reversal_busy: got 0 expected 1"); end
    checks++; if (downs != 15) begin errors++; $display("FAIL reversal_down_ticks: got %0d expected 15", downs); end
    checks++; if (zb != DEAD_CYCLES + 1) begin errors++; $display("FAIL reversal_zero_hold: got %0d expected %0d", zb, DEAD_CYCLES + 1); end
    checks++; if (pin_duty != 0) begin errors++; $display("FAIL reversal_pin_duty: got %0d expected 0", pin_duty); end
    checks++; if ({in1_a, in2_a} !== 2'b10) begin errors++; $display("FAIL reversal_pins: got %b expected 10", {in1_a, in2_a}); end
    checks++; if (!done) begin errors++; $display("FAIL reversal_ramp_back: got %0d expected %0d", duty_a, DUTY_HI); end
  endtask

  task automatic test_aborted_reversal();
    int mn;
    bit done, pins_ok, dead_seen;
    sw_dir[0] = 1'b0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      cyc();
      checks++; if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL abort_model t=%0t: got %h expected %h", $time, dut_outs(), exp_outs()); end
      done = (duty_a == 18'd9000);
    end
    checks++; if (!done) begin errors++; $display("FAIL abort_reach_9000: got %0d expected 9000", duty_a); end
    sw_dir[0] = 1'b1;
    mn = int'(duty_a); pins_ok = 1; dead_seen = 0;
    for (int i = 0; i < 120; i++) begin
      cyc();
      checks++; if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL abort_model t=%0t: got %h expected %h", $time, dut_outs(), exp_outs()); end
      if (int'(duty_a) < mn) mn = int'(duty_a);
      if (!(in1_a === 1'b1 && in2_a === 1'b0)) pins_ok = 0;
      if (busy[0] && duty_a == 18'd0) dead_seen = 1;
    end
    checks++; if (mn < 7000) begin errors++; $display("FAIL abort_min_duty: got %0d expected >= 7000", mn); end
    checks++; if (!pins_ok) begin errors++; $display("FAIL abort_pins: got changed expected held at 10"); end
    checks++; if (dead_seen) begin errors++; $display("FAIL abort_dead_time: got zero-duty hold expected none"); end
    checks++; if (duty_a !== 18'(DUTY_HI) || busy[0] !== 1'b0) begin errors++; $display("FAIL abort_final: got duty %0d busy %b expected %0d busy 0", duty_a, busy[0], DUTY_HI); end
  endtask

  task automatic test_glitch();
    int mx;
    bit pin_moved;
    sw_dir[1] = 1'b1;
    repeat (10) cyc();
    sw_en[1] = 1'b1;
    cyc(); cyc();
    sw_en[1] = 1'b0;
    mx = 0; pin_moved = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++; if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL glitch_model t=%0t: got %h expected %h", $time, dut_outs(), exp_outs()); end
      if (int'(duty_b) > mx) mx = int'(duty_b);
      if (in1_b !== 1'b0) pin_moved = 1;
    end
    checks++; if (mx != 0) begin errors++; $display("FAIL glitch_duty_b: got %0d expected 0", mx); end
    checks++; if (pin_moved) begin errors++; $display("FAIL glitch_pins_b: got moved expected in1_b 0"); end
    checks++; if (dut.g_ch[1].u_ch.state !== motor_cmd_pkg::ST_IDLE) begin errors++; $display("FAIL glitch_state_b: got %0d expected 0", dut.g_ch[1].u_ch.state); end
  endtask

  task automatic test_reset_mid_ramp();
    bit done;
    sw_spd[0] = 1'b1;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      cyc();
      checks++; if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL reset_mid_model t=%0t: got %h expected %h", $time, dut_outs(), exp_outs()); end
      done = (duty_a == 18'd7000);
    end
    checks++; if (!done) begin errors++; $display("FAIL reset_mid_reach_7000: got %0d expected 7000", duty_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (duty_a !== 18'd0) begin errors++; $display("FAIL reset_mid_duty_a: got %0d expected 0", duty_a); end
    checks++; if ({in1_a, in2_a} !== 2'b01) begin errors++; $display("FAIL reset_mid_pins: got %b expected 01", {in1_a, in2_a}); end
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL reset_mid_busy: got %b expected 00", busy); end
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_independence();
    bit done, a_ok;
    sw_en = 2'b11; sw_spd = 2'b00; sw_dir = 2'b11;
    rst_n = 1'b1;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      cyc();
      checks++; if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL indep_model t=%0t: got %h expected %h", $time, dut_outs(), exp_outs()); end
      done = (duty_a == 18'(DUTY_HI)) && (duty_b == 18'(DUTY_HI));
    end
    checks++; if (!done) begin errors++; $display("FAIL indep_reach_hi: got %0d/%0d expected %0d", duty_a, duty_b, DUTY_HI); end
    sw_en[1] = 1'b0;
    done = 0; a_ok = 1;
    for (int i = 0; i < 200 && !done; i++) begin
      cyc();
      checks++; if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL indep_model t=%0t: got %h expected %h", $time, dut_outs(), exp_outs()); end
      if (duty_a !== 18'(DUTY_HI)) a_ok = 0;
      done = (dut.g_ch[1].u_ch.state == motor_cmd_pkg::ST_IDLE);
    end
    checks++; if (!done) begin errors++; $display("FAIL indep_b_idle: got %0d expected 0", dut.g_ch[1].u_ch.state); end
    checks++; if (duty_b !== 18'd0 || busy[1] !== 1'b0) begin errors++; $display("FAIL indep_b_off: got duty %0d busy %b expected 0 busy 0", duty_b, busy[1]); end
    checks++; if (!a_ok) begin errors++; $display("FAIL indep_a_steady: got %0d expected %0d", duty_a, DUTY_HI); end
  endtask

  task automatic test_random();
    int hold;
    for (int n = 0; n < 60; n++) begin
      for (int c = 0; c < 2; c++) begin
        sw_en[c]  = ($urandom_range(0, 3) != 0);
        sw_dir[c] = ($urandom_range(0, 2) == 0) ? ~sw_dir[c] : sw_dir[c];
        sw_spd[c] = 1'($urandom_range(0, 1));
      end
      hold = $urandom_range(1, 40);
      repeat (hold) begin
        cyc();
        checks++; if (dut_outs() !== exp_outs()) begin errors++; $display("FAIL random_model t=%0t: got %h expected %h", $time, dut_outs(), exp_outs()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_soft_start();
    test_reversal();
    test_aborted_reversal();
    test_glitch();
    test_reset_mid_ramp();
    test_independence();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/motor_cmd_ramp.md
# motor_cmd_ramp

- Upstream command stage for the dual-channel H-bridge PWM generator.
- Turns raw board switches (enable, direction, speed select per channel) into clean motor commands:
  - a soft-start/soft-stop duty compare value per channel;
  - a safe direction-pin pair per channel.
- The downstream PWM stage compares its 0..PERIOD counter against `duty_*`.
- Reversal is always ramp-to-zero, dead time, flip, ramp-up; the bridge never sees a direction change under load.

## Interface
- `PERIOD`, 200000, PWM counter terminal value; duty saturates here.
- `DUTY_LO`, 50000, target duty when speed select = 1 (25 %).
- `DUTY_HI`, 150000, target duty when speed select = 0 (75 %).
- `RAMP_DIV`, 100000, cycles between ramp ticks.
- `RAMP_STEP`, 5000, duty change per ramp tick.
- `DEAD_CYCLES`, 1000000, zero-duty hold before a direction flip.
- `DEB_CYCLES`, 500000, stable cycles required to accept a switch change.
- `CLK100MHZ`  in  1  system clock; all logic on rising edge.
- `CPU_RESETN`  in  1  asynchronous, active-low reset.
- `sw_en`  in  2  channel enable, [0] = A, [1] = B.
- `sw_dir`  in  2  requested direction per channel.
- `sw_spd`  in  2  speed select per channel.
- `duty_a`, `duty_b`  out  18  compare value for the PWM stage.
- `in1_a`, `in2_a`, `in1_b`, `in2_b`  out  1  bridge direction pins: `in1` = dir_q, `in2` = ~dir_q.
- `busy`  out  2  channel is in DECEL or DEAD.

## Operation
- Every switch input passes through a 2-FF synchronizer, then a debouncer.
- Debounced value updates on the cycle after the synchronized value has been equal for DEB_CYCLES consecutive cycles.
- Shared ramp tick:
  - pulses one cycle every RAMP_DIV cycles;
  - the free-running divider starts at 0 on reset release, so the first tick is on cycle RAMP_DIV-1.
- Per-channel state machine, with states IDLE, RUN, DECEL, DEAD:
  - **IDLE**: duty = 0. If en_db = 1, load dir_q ← dir_db and go to RUN. A direction flip at zero duty needs no dead time.
  - **RUN**: target = en_db ? (spd_db ? DUTY_LO : DUTY_HI) : 0.
    - On a tick, duty moves RAMP_STEP toward target, clamped so it never crosses target.
    - If dir_db ≠ dir_q, go to DECEL.
    - If en_db = 0 and duty = 0, go to IDLE.
  - **DECEL**: target = 0, ramping as in RUN.
    - If dir_db returns to dir_q before duty reaches 0, go back to RUN and ramp up from the current duty.
    - When duty = 0, go to DEAD and clear the dead counter.
  - **DEAD**: duty = 0 and pins hold; count DEAD_CYCLES cycles.
    - On expiry, dir_q ← dir_db (the current value).
    - Then go to RUN if en_db = 1, else IDLE.
    - dir_db toggling during DEAD does not restart the count.
- Speed-select changes in RUN only move the target; ramping proceeds at the normal rate, with no dead time.
- Duty arithmetic is 18-bit unsigned:
  - step-down: if duty < RAMP_STEP, next duty = 0;
  - step-up: saturate at min(target, PERIOD).
- Channels are fully independent apart from the shared tick.

## Timing
- Reset values:
  - duty_a = duty_b = 0;
  - dir_q = 0, so in1 = 0 and in2 = 1;
  - busy = 0;
  - states = IDLE;
  - debounced values = 0;
  - divider and counters = 0.
- Reset asserted mid-ramp forces every output to its reset value asynchronously. No ramp-down is performed.
- Switch-to-debounced latency = 2 + DEB_CYCLES cycles.
- Duty register updates on the tick cycle and is visible on the following cycle.
- State transitions are registered, so a condition seen in cycle n gives the new state in cycle n+1.
- Direction pins change only on the DEAD-expiry cycle or the IDLE→RUN cycle, and are registered.
- Duty is guaranteed 0 on the cycle a pin changes.

## Structure
- Package `motor_cmd_pkg` holds:
  - the state enum (IDLE, RUN, DECEL, DEAD);
  - the 18-bit duty type;
  - default constants PERIOD, DUTY_LO, DUTY_HI.
- Sub-module `motor_ramp_channel` contains one channel's synchronizer, debouncer, FSM and duty register.
- It is instantiated twice; the top holds the tick divider and the output mapping.

## Test plan
Bench parameters: RAMP_DIV=4, RAMP_STEP=1000, DUTY_LO=5000, DUTY_HI=15000, DEAD_CYCLES=8, DEB_CYCLES=3.

1. **Soft start.** Assert sw_en[0]=1, sw_spd[0]=1 after reset → duty_a climbs 1000 per tick to 5000 and holds; in1_a=0, in2_a=1.
2. **Reversal.** At duty_a=15000, toggle sw_dir[0] →
   - busy[0]=1;
   - duty_a falls to 0 in 15 ticks;
   - holds 8 cycles;
   - in1_a=1, in2_a=0;
   - duty_a ramps back to 15000;
   - duty_a is 0 on the pin-change cycle.
3. **Aborted reversal.** Toggle sw_dir[0] and restore it while duty_a=9000 → returns to RUN, no dead time, pins unchanged, ramps back up from the current value.
4. **Glitch rejection.** Pulse sw_en[1] for 2 cycles → duty_b stays 0 and the state stays IDLE.
5. **Reset mid-ramp.** Pull CPU_RESETN low with duty_a=7000 → duty_a=0, in2_a=1, busy=0 immediately, before the next clock edge.
6. **Independence and disable.** With both channels running, clear sw_en[1] → duty_b ramps to 0 and returns to IDLE; duty_a is unaffected.
